// File: rtl/trng_collector.sv
// trng_collector: gathers bits from an external entropy source into words.
// Each bit is requested with a trng_req pulse, given time to settle, then
// sampled through a two-flop synchronizer. A repetition-count health test
// watches the sampled stream and stops collection on a stuck source.
module trng_collector #(
  parameter int WORD_BITS     = 32,
  parameter int SETTLE_CYCLES = 4,
  parameter int REP_LIMIT     = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 trng_bit,
  output logic                 trng_req,
  output logic [WORD_BITS-1:0] word_data,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 health_fail,
  input  logic                 health_clr
);

  localparam int               BCW         = $clog2(WORD_BITS + 1);
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       REP_MAX     = 8'(REP_LIMIT);
  localparam logic [BCW-1:0]   BIT_LAST    = BCW'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SAMPLE = 2'd2,
    FULL   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             sync_p0;
  logic             sbit;
  logic [7:0]       settle_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic [7:0]       run_cnt;
  logic             prev_bit;
  logic             sample_en;
  logic             settle_done;
  logic             word_done;
  logic             trip;
  logic             clr_fail;
  logic [7:0]       run_next;

  // Repetition count update: a zero count means no sample has been seen
  // since reset or clear, so the next sample starts a fresh run of one.
  // The count saturates at the trip threshold.
  function automatic logic [7:0] run_update(input logic [7:0] run,
                                            input logic       same);
    logic [7:0] res;
    if (run == 8'd0 || !same) begin
      res = 8'd1;
    end else if (run >= REP_MAX) begin
      res = REP_MAX;
    end else begin
      res = run + 8'd1;
    end
    return res;
  endfunction

  // Decode the per-cycle events shared by the state and datapath logic.
  always_comb begin
    sample_en   = (state == SAMPLE);
    settle_done = (state == REQ) && (settle_cnt == SETTLE_LAST);
    word_done   = sample_en && (bit_cnt == BIT_LAST);
    run_next    = run_update(run_cnt, sbit == prev_bit);
    // A clear in the same cycle as the detection wins, so no trip then.
    trip        = sample_en && (run_next == REP_MAX) && !health_clr;
    clr_fail    = health_clr && health_fail;
  end

  // Two-flop synchronizer for the asynchronous entropy bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b0;
      sbit    <= 1'b0;
    end else begin
      sync_p0 <= trng_bit;
      sbit    <= sync_p0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a health trip takes priority over word completion
  // so a word whose last bit trips the test is never presented.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!health_fail) state_next = REQ;
      REQ:     if (settle_done) state_next = SAMPLE;
      SAMPLE: begin
        if (trip) begin
          state_next = IDLE;
        end else if (word_done) begin
          state_next = FULL;
        end else begin
          state_next = REQ;
        end
      end
      FULL:    if (word_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr_fail) begin
      state_next = IDLE;
    end
  end

  // Outputs decoded directly from the registered state.
  always_comb begin
    trng_req   = (state == REQ);
    word_valid = (state == FULL);
  end

  // Settle counter: counts the cycles trng_req has been high for this bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      settle_cnt <= 8'd0;
    end else if ((state == REQ) && !settle_done) begin
      settle_cnt <= settle_cnt + 8'd1;
    end else begin
      settle_cnt <= 8'd0;
    end
  end

  // Word assembly: shift sampled bits in at the LSB; drop a partial word on
  // a health trip or a failure clear, restart the count after a handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt   <= '0;
      word_data <= '0;
    end else if (trip || clr_fail) begin
      bit_cnt   <= '0;
      word_data <= '0;
    end else if (sample_en) begin
      bit_cnt   <= bit_cnt + BCW'(1);
      word_data <= {word_data[WORD_BITS-2:0], sbit};
    end else if ((state == FULL) && word_ready) begin
      bit_cnt   <= '0;
    end
  end

  // Repetition-count health test with a sticky failure flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_cnt     <= 8'd0;
      prev_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else if (health_clr) begin
      run_cnt     <= 8'd0;
      health_fail <= 1'b0;
    end else begin
      if (sample_en) begin
        run_cnt  <= run_next;
        prev_bit <= sbit;
      end
      if (trip) begin
        health_fail <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: drives a scripted/random entropy source in response to
// trng_req and compares the collector against a word/run model built from
// the bits the bench handed out.
module tb_trng_collector;

  localparam int WB = 32;
  localparam int SC = 4;
  localparam int RL = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          trng_bit;
  logic          trng_req;
  logic [WB-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          health_fail;
  logic          health_clr;

  trng_collector #(
    .WORD_BITS     (WB),
    .SETTLE_CYCLES (SC),
    .REP_LIMIT     (RL)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .trng_bit    (trng_bit),
    .trng_req    (trng_req),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .health_fail (health_fail),
    .health_clr  (health_clr)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   mode;
  logic alt_next;
  logic last_bit;
  int   cur_run;
  logic req_prev;
  int   pushes;
  int   req_hi;
  int   req_rise;
  int   cur_hi;
  int   hi_bad;
  logic word_q[$];
  logic run_q[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected word: the bits handed out since the word started, first in MSB.
  function automatic logic [WB-1:0] model_word();
    logic [WB-1:0] w;
    w = '0;
    foreach (word_q[i]) w = {w[WB-2:0], word_q[i]};
    return w;
  endfunction

  // Length of the trailing run of identical bits since reset/clear.
  function automatic int model_run();
    int r;
    r = 0;
    for (int i = run_q.size() - 1; i >= 0; i--) begin
      if (run_q[i] == run_q[run_q.size() - 1]) r++;
      else break;
    end
    return (r > RL) ? RL : r;
  endfunction

  // One clock: sample at the falling edge, answer a new request with a bit.
  task automatic tick();
    logic b;
    @(negedge clk);
    if (trng_req) begin
      cur_hi++;
      req_hi++;
    end else if (req_prev) begin
      if (cur_hi != SC) hi_bad++;
      cur_hi = 0;
    end
    if (trng_req && !req_prev) begin
      req_rise++;
      case (mode)
        0: begin
          b = alt_next;
          alt_next = ~alt_next;
        end
        1: b = 1'b1;
        default: begin
          b = 1'($urandom_range(0, 1));
          if (cur_run >= 20 && b == last_bit) b = ~b;
        end
      endcase
      if (b == last_bit) cur_run++;
      else cur_run = 1;
      last_bit = b;
      trng_bit = b;
      word_q.push_back(b);
      run_q.push_back(b);
      pushes++;
    end
    req_prev = trng_req;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!trng_req && n < 10);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!word_valid && n < 400);
  endtask

  task automatic do_reset(input int m);
    resetn     = 1'b0;
    word_ready = 1'b0;
    health_clr = 1'b0;
    trng_bit   = 1'b0;
    mode       = m;
    alt_next   = 1'b1;
    tick();
    tick();
    word_q.delete();
    run_q.delete();
    pushes = 0;
    cur_hi = 0;
    resetn = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int err;
    int vseen;
    int p;
    logic [WB-1:0] saved;

    resetn = 1'b0; trng_bit = 1'b0; word_ready = 1'b0; health_clr = 1'b0;
    mode = 0; alt_next = 1'b1; last_bit = 1'b0; cur_run = 0; req_prev = 1'b0;
    pushes = 0; req_hi = 0; req_rise = 0; cur_hi = 0; hi_bad = 0;
    tick();
    tick();
    check("rst_req", trng_req, 0);
    check("rst_valid", word_valid, 0);
    check("rst_data", word_data, 0);
    check("rst_fail", health_fail, 0);

    // Alternating source: 1,0,1,0... -> 0xAAAAAAAA after 160 cycles.
    word_q.delete(); run_q.delete();
    req_hi = 0; req_rise = 0; hi_bad = 0;
    resetn = 1'b1;
    wait_req(n);
    check("a_req_delay", n, 1);
    wait_valid(n);
    check("a_latency", n, 160);
    check("a_data", word_data, 32'hAAAA_AAAA);
    check("a_model", word_data, model_word());
    check("a_req_high", req_hi, 32 * SC);
    check("a_req_pulses", req_rise, 32);
    check("a_pulse_shape", hi_bad, 0);
    check("a_fail", health_fail, 0);

    // Back-pressure: word held stable, no requests while waiting.
    saved = word_data;
    err = 0;
    repeat (50) begin
      tick();
      if (word_data !== saved || trng_req !== 1'b0 || word_valid !== 1'b1) err++;
    end
    check("b_hold", err, 0);
    word_ready = 1'b1;
    tick();
    check("b_valid_drop", word_valid, 0);
    check("b_req_gap", trng_req, 0);
    mode = 2;
    word_q.delete();
    hi_bad = 0;
    tick();
    check("b_req_restart", trng_req, 1);

    // Random words with word_ready held high throughout.
    for (int w = 0; w < 3; w++) begin
      wait_valid(n);
      check("c_latency", n, 160);
      check("c_data", word_data, model_word());
      check("c_bits", word_q.size(), WB);
      tick();
      check("c_drop", word_valid, 0);
      word_q.delete();
      tick();
      check("c_req", trng_req, 1);
    end
    check("c_fail", health_fail, 0);
    check("c_pulse_shape", hi_bad, 0);

    // Stuck-at-one source trips the health test on the 32nd sample.
    do_reset(1);
    wait_req(n);
    n = 0;
    vseen = 0;
    do begin
      tick();
      n++;
      if (word_valid) vseen++;
    end while (!health_fail && n < 400);
    check("d_fail", health_fail, 1);
    check("d_latency", n, 160);
    check("d_bits", pushes, RL);
    check("d_run", model_run(), RL);
    check("d_no_word", vseen, 0);
    err = 0;
    p = pushes;
    repeat (50) begin
      tick();
      if (trng_req || word_valid || !health_fail) err++;
    end
    check("d_quiet", err, 0);
    check("d_no_req", pushes, p);

    // Clear the failure and collect a fresh random word.
    mode = 2;
    word_q.delete();
    run_q.delete();
    health_clr = 1'b1;
    tick();
    health_clr = 1'b0;
    check("e_clr", health_fail, 0);
    check("e_idle", trng_req, 0);
    tick();
    check("e_req", trng_req, 1);
    wait_valid(n);
    check("e_latency", n, 160);
    check("e_data", word_data, model_word());
    check("e_fail", health_fail, 0);
    check("e_run_ok", model_run() < RL, 1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;

    // Clear coinciding with the sample that would trip the test.
    do_reset(1);
    n = 0;
    while (!(pushes == RL && !trng_req) && n < 400) begin
      tick();
      n++;
    end
    health_clr = 1'b1;
    run_q.delete();
    tick();
    health_clr = 1'b0;
    check("f_no_fail", health_fail, 0);
    check("f_valid", word_valid, 1);
    check("f_data", word_data, model_word());
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    word_q.delete();
    p = pushes;
    n = 0;
    vseen = 0;
    do begin
      tick();
      n++;
      if (word_valid) vseen++;
    end while (!health_fail && n < 400);
    check("f_refail", health_fail, 1);
    check("f_bits", pushes - p, RL);
    check("f_run", model_run(), RL);
    check("f_no_word", vseen, 0);

    // Asynchronous reset after 17 bits sampled.
    do_reset(2);
    n = 0;
    while (pushes < 18 && n < 400) begin
      tick();
      n++;
    end
    #2 resetn = 1'b0;
    #1;
    check("g_req", trng_req, 0);
    check("g_valid", word_valid, 0);
    check("g_data", word_data, 0);
    check("g_fail", health_fail, 0);
    word_q.delete();
    run_q.delete();
    pushes = 0;
    tick();
    resetn = 1'b1;
    wait_req(n);
    check("g_req_delay", n, 1);
    wait_valid(n);
    check("g_latency", n, 160);
    check("g_data_new", word_data, model_word());
    check("g_bits", word_q.size(), WB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trng_collector.md
TRNG_COLLECTOR -- requirements
Module: trng_collector

Interface
REQ-001 The block SHALL have parameter WORD_BITS, default 32, meaning the width of each assembled random word.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4, range 3..255, meaning the number of cycles trng_req is held high per bit request.
REQ-003 The block SHALL have parameter REP_LIMIT, default 32, range 2..255, meaning the run length of identical bits that trips the health test.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port trng_bit  input  1  raw entropy bit from the external source, asynchronous to clk.
REQ-007 The block SHALL have port trng_req  output  1  bit request strobe to the entropy source.
REQ-008 The block SHALL have port word_data  output  WORD_BITS  assembled random word.
REQ-009 The block SHALL have port word_valid  output  1  word_data holds a complete word.
REQ-010 The block SHALL have port word_ready  input  1  consumer accepts the word.
REQ-011 The block SHALL have port health_fail  output  1  sticky repetition-count failure flag.
REQ-012 The block SHALL have port health_clr  input  1  single-cycle clear of health_fail.

Function
REQ-013 trng_bit SHALL pass through a two-flop synchronizer before any use; only the second flop output (sbit) is sampled.
REQ-014 The FSM SHALL have states IDLE, REQ, SAMPLE and FULL.
REQ-015 IDLE -> REQ on the first cycle after reset release, provided health_fail is 0.
REQ-016 In REQ, trng_req = 1 for exactly SETTLE_CYCLES consecutive cycles, counted by a settle counter; then -> SAMPLE.
REQ-017 In SAMPLE, trng_req = 0; sbit shifts into word_data LSB (word_data <= {word_data[WORD_BITS-2:0], sbit}) and the bit counter increments.
REQ-018 From SAMPLE: if bit count reaches WORD_BITS, -> FULL with word_valid = 1 on the next cycle; otherwise -> REQ.
REQ-019 Per-bit period SHALL be SETTLE_CYCLES+1 cycles; word latency SHALL be WORD_BITS*(SETTLE_CYCLES+1) cycles (160 at defaults) from entering REQ.
REQ-020 In FULL, word_valid = 1 and word_data SHALL stay stable until a cycle with word_valid & word_ready; trng_req = 0 throughout FULL.
REQ-021 On the handshake cycle, word_valid SHALL drop and bit count reset; the FSM enters REQ on the next cycle.
REQ-022 word_ready while word_valid = 0 SHALL have no effect.
REQ-023 Health test: run counter = 1 on the first sampled bit after reset or clear; +1 when sbit equals the previous sample; reset to 1 otherwise; saturates at REP_LIMIT.
REQ-024 When the run counter reaches REP_LIMIT, health_fail SHALL set on the following cycle, the FSM SHALL enter IDLE, and the partial word SHALL be discarded (bit count 0).
REQ-025 While health_fail = 1: trng_req = 0, word_valid = 0, no sampling.
REQ-026 A failure detected while in FULL SHALL be impossible by construction, since no sampling occurs in FULL.
REQ-027 On health_clr: health_fail <= 0; run counter and bit count reset; FSM -> IDLE, then REQ next cycle.
REQ-028 If health_clr coincides with a failure detection, clear SHALL win: health_fail = 0 and the run counter restarts.
REQ-029 health_clr while health_fail = 0 SHALL reset only the run counter; collection continues.

Reset
REQ-030 While resetn = 0, the block SHALL hold: trng_req = 0, word_valid = 0, word_data = 0, health_fail = 0, FSM = IDLE, all counters 0, synchronizer flops 0.
REQ-031 Reset asserted mid-word SHALL discard all partial state immediately (asynchronous); collection restarts from bit 0 after release.

Verification
REQ-032 Reset release, trng_bit alternating 1/0 per request -> trng_req pulses 4 cycles high / 1 low; word_valid = 1 at cycle 160 with word_data = 0xAAAAAAAA.
REQ-033 word_ready held 0 for 50 cycles after valid -> word_data stable, trng_req = 0; word_ready = 1 -> valid drops next cycle, trng_req = 1 the cycle after.
REQ-034 trng_bit stuck at 1 -> health_fail = 1 after the 32nd sample; trng_req = 0 and word_valid = 0 thereafter, with no partial word ever presented.
REQ-035 health_clr pulse with health_fail set and random input -> health_fail = 0, a fresh full 32-bit word arrives 160 cycles after restart.
REQ-036 health_clr on the same cycle the run counter reaches 32 -> health_fail remains 0.
REQ-037 resetn pulsed low after 17 bits sampled -> all outputs 0 asynchronously; the next word takes a full 160 cycles.
